input_debounce: RTL and testbench



---
 rtl/input_debounce.sv | 65 ++++++
 tb/tb_input_debounce.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/input_debounce.sv
// input_debounce: two-flop synchroniser plus tick-paced per-bit debounce
// with registered clean levels and one-cycle rise/fall strobes.
module input_debounce #(
    parameter int WIDTH        = 6,
    parameter int TICK_CYCLES  = 50_000,
    parameter int STABLE_TICKS = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] clean,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             tick
);
    localparam int TW = $clog2(TICK_CYCLES);
    localparam int CW = $clog2(STABLE_TICKS + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(STABLE_TICKS - 1);

    logic [WIDTH-1:0] s1, s2;
    logic [TW-1:0]    tick_cnt;
    logic [CW-1:0]    cnt [WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1       <= '0;
            s2       <= '0;
            tick_cnt <= '0;
            tick     <= 1'b0;
        end else begin
            s1       <= raw;
            s2       <= s1;
            tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + TW'(1);
            tick     <= tick_cnt == TICK_LAST;
        end
    end

    // A bounce back to the held level discards any accumulated ticks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clean <= '0;
            rise  <= '0;
            fall  <= '0;
            for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
        end else begin
            rise <= '0;
            fall <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                if (s2[i] == clean[i]) begin
                    cnt[i] <= '0;
                end else if (tick) begin
                    if (cnt[i] == CNT_LAST) begin
                        clean[i] <= s2[i];
                        rise[i]  <= s2[i];
                        fall[i]  <= ~s2[i];
                        cnt[i]   <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + CW'(1);
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_input_debounce.sv
// tb_input_debounce: directed checks of synchroniser, tick pacing, debounce
// latency, glitch rejection, strobes and asynchronous reset.
module tb_input_debounce;
    localparam int W = 6;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] raw = '0;
    logic [W-1:0] clean, rise, fall;
    logic         tick;
    logic [0:0]   raw_b = '0;
    logic [0:0]   clean_b, rise_b, fall_b;
    logic         tick_b;

    int total = 0;
    int bad = 0;
    int rise_n [W];
    int fall_n [W];
    int hi_n [W];
    int tick_n;

    always #5 clk = ~clk;

    input_debounce #(.WIDTH(W), .TICK_CYCLES(4), .STABLE_TICKS(3)) dut (
        .clk(clk), .rst_n(rst_n), .raw(raw),
        .clean(clean), .rise(rise), .fall(fall), .tick(tick)
    );

    input_debounce #(.WIDTH(1), .TICK_CYCLES(100), .STABLE_TICKS(10)) dut_big (
        .clk(clk), .rst_n(rst_n), .raw(raw_b),
        .clean(clean_b), .rise(rise_b), .fall(fall_b), .tick(tick_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        tick_n += int'(tick);
        for (int i = 0; i < W; i++) begin
            rise_n[i] += int'(rise[i]);
            fall_n[i] += int'(fall[i]);
            hi_n[i]   += int'(clean[i]);
        end
    endtask

    task automatic clr();
        tick_n = 0;
        for (int i = 0; i < W; i++) begin
            rise_n[i] = 0;
            fall_n[i] = 0;
            hi_n[i]   = 0;
        end
    endtask

    function automatic logic [W-1:0] rmask(input int n);
        logic [W-1:0] m;
        for (int i = 0; i < W; i++) m[i] = (rise_n[i] == n);
        return m;
    endfunction

    function automatic logic [W-1:0] fmask(input int n);
        logic [W-1:0] m;
        for (int i = 0; i < W; i++) m[i] = (fall_n[i] == n);
        return m;
    endfunction

    initial begin
        logic [W-1:0] cap_r, cap_f;
        int n, t1;

        // reset with all switches already high
        clr();
        raw = 6'h3F;
        repeat (3) step();
        check("rst_hold", {clean, rise, fall, tick}, 0);
        rst_n = 1'b1;
        clr();
        n = 0; t1 = 0; cap_r = '0;
        for (int e = 1; e <= 20; e++) begin
            step();
            if (tick && t1 == 0) t1 = e;
            if (clean == 6'h3F && n == 0) begin n = e; cap_r = rise; end
        end
        check("rst_tick_first", t1, 4);
        check("rst_tick_count", tick_n, 5);
        check("rst_clean_edge", n, 13);
        check("rst_rise_val", cap_r, 6'h3F);
        check("rst_rise_once", rmask(1), 6'h3F);
        check("rst_no_fall", fmask(0), 6'h3F);

        // clean step on bit 0
        raw = '0;
        repeat (20) step();
        check("prep_zero", clean, 0);
        clr();
        raw = 6'h01;
        n = 0; cap_r = '0;
        for (int e = 1; e <= 30; e++) begin
            step();
            if (clean[0] && n == 0) begin n = e; cap_r = rise; end
        end
        check("step_lat", n >= 11 && n <= 14, 1);
        check("step_rise_now", cap_r, 6'h01);
        check("step_rise_once", rise_n[0], 1);
        check("step_no_fall", fmask(0), 6'h3F);

        // 8-cycle glitches on bit 2 at shifting tick phases
        for (int p = 0; p < 4; p++) begin
            clr();
            repeat (p) step();
            raw[2] = 1'b1;
            repeat (8) step();
            raw[2] = 1'b0;
            repeat (6) step();
            check($sformatf("glitch_p%0d", p), hi_n[2] + rise_n[2], 0);
        end

        // bit 5 bounces every 3 cycles, then settles high
        clr();
        for (int k = 0; k < 10; k++) begin
            raw[5] = (k % 2 == 0);
            repeat (3) step();
        end
        check("bounce_hold", hi_n[5], 0);
        raw[5] = 1'b1;
        repeat (20) step();
        check("bounce_rise_once", rise_n[5], 1);
        check("bounce_no_fall", fall_n[5], 0);
        check("bounce_level", clean[5], 1);

        // simultaneous bits
        raw = '0;
        repeat (20) step();
        clr();
        raw = 6'h15;
        cap_r = '0;
        for (int e = 0; e < 20 && cap_r == 0; e++) begin
            step();
            cap_r = rise;
        end
        repeat (4) step();
        check("simul_rise", cap_r, 6'h15);
        check("simul_rise_once", rmask(1), 6'h3F & ~6'h2A);
        clr();
        raw = 6'h2A;
        cap_r = '0; cap_f = '0;
        for (int e = 0; e < 20 && cap_f == 0; e++) begin
            step();
            cap_f = fall;
            cap_r = rise;
        end
        check("swap_fall", cap_f, 6'h15);
        check("swap_rise", cap_r, 6'h2A);
        check("swap_level", clean, 6'h2A);

        // reset pulse while bit 1 has two ticks counted
        raw = 6'h20;
        repeat (20) step();
        check("prep_20", clean, 6'h20);
        n = 0;
        do begin step(); n++; end while (!tick && n < 10);
        raw = 6'h22;
        repeat (10) step();
        rst_n = 1'b0;
        #1;
        check("rst_async", {clean, rise, fall, tick}, 0);
        step();
        check("rst_mid_hold", {clean, rise, fall, tick}, 0);
        rst_n = 1'b1;
        clr();
        n = 0; cap_r = '0;
        for (int e = 1; e <= 20; e++) begin
            step();
            if (clean[1] && n == 0) begin n = e; cap_r = rise; end
        end
        check("rst_mid_lat", n >= 11 && n <= 14, 1);
        check("rst_mid_rise", cap_r, 6'h22);

        // larger parameter set: latency window (S-1)*T+1 .. S*T+2
        raw_b = 1'b1;
        n = 0; cap_r = '0;
        for (int e = 1; e <= 1100 && n == 0; e++) begin
            @(posedge clk);
            #1;
            if (clean_b[0]) begin n = e; cap_r[0] = rise_b[0]; end
        end
        check("big_lat", n >= 901 && n <= 1002, 1);
        check("big_rise", cap_r[0], 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
